// File: rtl/draw_cmd_arbiter.sv
// draw_cmd_arbiter: shares one triangle draw engine between NREQ command sources.
// Round-robin grant over valid/ready, vertex capture with power-of-two scaling,
// engine start/done handshake and a per-requester completion pulse.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid_i / req_ready_o per-requester command handshake (ready is one-hot, IDLE only)
//   req_vert_i                per requester {y2,x2,y1,x1,y0,x0}, x0 in LSBs, req 0 lowest
//   req_cidx_i                per-requester colour index
//   cmd_done_o                one-cycle completion pulse for the granted requester
//   grant_id_o                index of the requester owning the engine
//   busy_o                    high from accept through the completion pulse
//   eng_start_o               one-cycle start pulse to the draw engine
//   eng_x0_o..eng_y2_o        scaled vertices, held while busy
//   eng_cidx_o                colour index, held while busy
//   eng_done_i                engine completion pulse
module draw_cmd_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned CORDW = 16,
  parameter int unsigned CIDXW = 4,
  parameter int unsigned SCALE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [NREQ*6*CORDW-1:0]    req_vert_i,
  input  logic [NREQ*CIDXW-1:0]      req_cidx_i,
  output logic [NREQ-1:0]            cmd_done_o,
  output logic [$clog2(NREQ)-1:0]    grant_id_o,
  output logic                       busy_o,
  output logic                       eng_start_o,
  output logic signed [CORDW-1:0]    eng_x0_o,
  output logic signed [CORDW-1:0]    eng_y0_o,
  output logic signed [CORDW-1:0]    eng_x1_o,
  output logic signed [CORDW-1:0]    eng_y1_o,
  output logic signed [CORDW-1:0]    eng_x2_o,
  output logic signed [CORDW-1:0]    eng_y2_o,
  output logic [CIDXW-1:0]           eng_cidx_o,
  input  logic                       eng_done_i
);

  localparam int unsigned IDW   = $clog2(NREQ);
  localparam int unsigned VW    = 6 * CORDW;
  // Scaling by 1/2/4 is a left shift; overflow wraps (no saturation).
  localparam int unsigned SHIFT = (SCALE == 4) ? 2 : ((SCALE == 2) ? 1 : 0);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_e;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   grant_q;
  logic [CORDW-1:0] vert_q [6];
  logic [CIDXW-1:0] cidx_q;
  logic             busy_q;
  logic             start_q;
  logic [NREQ-1:0]  done_q;

  logic [IDW-1:0]   grant_c;
  logic             any_valid_c;
  logic [VW-1:0]    sel_vert_c;
  logic [CIDXW-1:0] sel_cidx_c;

  // Round-robin search starting at ptr_q; first valid requester wins.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx         = 0;
    found       = 1'b0;
    grant_c     = ptr_q;
    any_valid_c = |req_valid_i;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid_i[IDW'(idx)]) begin
        grant_c = IDW'(idx);
        found   = 1'b1;
      end
    end
  end

  // Payload of the requester being granted this cycle.
  always_comb begin
    sel_vert_c = VW'(req_vert_i >> (32'(grant_c) * VW));
    sel_cidx_c = CIDXW'(req_cidx_i >> (32'(grant_c) * CIDXW));
  end

  // Ready depends only on state and valid, never on itself.
  assign req_ready_o = (state_q == IDLE && any_valid_c) ? (NREQ'(1) << grant_c) : '0;

  // Arbitration / engine handshake FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cidx_q  <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= '0;
      for (int k = 0; k < 6; k++) vert_q[k] <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      case (state_q)
        IDLE: begin
          if (any_valid_c) begin
            grant_q <= grant_c;
            for (int k = 0; k < 6; k++) vert_q[k] <= sel_vert_c[k*CORDW +: CORDW] << SHIFT;
            cidx_q  <= sel_cidx_c;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          // A done arriving alongside start is a zero-length draw.
          if (eng_done_i) begin
            done_q  <= NREQ'(1) << grant_q;
            state_q <= DONE;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (eng_done_i) begin
            done_q  <= NREQ'(1) << grant_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          ptr_q   <= (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_id_o  = grant_q;
  assign busy_o      = busy_q;
  assign eng_start_o = start_q;
  assign cmd_done_o  = done_q;
  assign eng_x0_o    = vert_q[0];
  assign eng_y0_o    = vert_q[1];
  assign eng_x1_o    = vert_q[2];
  assign eng_y1_o    = vert_q[3];
  assign eng_x2_o    = vert_q[4];
  assign eng_y2_o    = vert_q[5];
  assign eng_cidx_o  = cidx_q;

endmodule

// File: tb/tb_draw_cmd_arbiter.sv
// tb_draw_cmd_arbiter: directed bench for draw_cmd_arbiter.
// Instances: main (NREQ=2, SCALE=1), s2 (SCALE=2, shares main inputs),
// s4 (CORDW=10, SCALE=4) and r3 (NREQ=3) for round-robin order.
module tb_draw_cmd_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // main instance (and s2 inputs)
  logic [1:0]          valid, ready, done;
  logic [191:0]        vert;
  logic [7:0]          cidx;
  logic [0:0]          gid;
  logic                busy, start, edone;
  logic signed [15:0]  x0, y0, x1, y1, x2, y2;
  logic [3:0]          ecidx;

  // s2 outputs
  logic [1:0]          s2_ready, s2_done;
  logic [0:0]          s2_gid;
  logic                s2_busy, s2_start;
  logic signed [15:0]  s2_x0, s2_y0, s2_x1, s2_y1, s2_x2, s2_y2;
  logic [3:0]          s2_cidx;

  // s4 instance
  logic [1:0]          valid4, ready4, done4;
  logic [119:0]        vert4;
  logic [7:0]          cidx4;
  logic [0:0]          gid4;
  logic                busy4, start4, edone4;
  logic signed [9:0]   x0_4, y0_4, x1_4, y1_4, x2_4, y2_4;
  logic [3:0]          ecidx4;

  // r3 instance
  logic [2:0]          valid3, ready3, done3;
  logic [287:0]        vert3;
  logic [11:0]         cidx3;
  logic [1:0]          gid3;
  logic                busy3, start3, edone3;
  logic signed [15:0]  x0_3, y0_3, x1_3, y1_3, x2_3, y2_3;
  logic [3:0]          ecidx3;

  draw_cmd_arbiter #(.NREQ(2), .CORDW(16), .CIDXW(4), .SCALE(1)) u_main (
    .clk(clk), .rst(rst), .req_valid_i(valid), .req_ready_o(ready), .req_vert_i(vert),
    .req_cidx_i(cidx), .cmd_done_o(done), .grant_id_o(gid), .busy_o(busy),
    .eng_start_o(start), .eng_x0_o(x0), .eng_y0_o(y0), .eng_x1_o(x1), .eng_y1_o(y1),
    .eng_x2_o(x2), .eng_y2_o(y2), .eng_cidx_o(ecidx), .eng_done_i(edone));

  draw_cmd_arbiter #(.NREQ(2), .CORDW(16), .CIDXW(4), .SCALE(2)) u_s2 (
    .clk(clk), .rst(rst), .req_valid_i(valid), .req_ready_o(s2_ready), .req_vert_i(vert),
    .req_cidx_i(cidx), .cmd_done_o(s2_done), .grant_id_o(s2_gid), .busy_o(s2_busy),
    .eng_start_o(s2_start), .eng_x0_o(s2_x0), .eng_y0_o(s2_y0), .eng_x1_o(s2_x1),
    .eng_y1_o(s2_y1), .eng_x2_o(s2_x2), .eng_y2_o(s2_y2), .eng_cidx_o(s2_cidx),
    .eng_done_i(edone));

  draw_cmd_arbiter #(.NREQ(2), .CORDW(10), .CIDXW(4), .SCALE(4)) u_s4 (
    .clk(clk), .rst(rst), .req_valid_i(valid4), .req_ready_o(ready4), .req_vert_i(vert4),
    .req_cidx_i(cidx4), .cmd_done_o(done4), .grant_id_o(gid4), .busy_o(busy4),
    .eng_start_o(start4), .eng_x0_o(x0_4), .eng_y0_o(y0_4), .eng_x1_o(x1_4),
    .eng_y1_o(y1_4), .eng_x2_o(x2_4), .eng_y2_o(y2_4), .eng_cidx_o(ecidx4),
    .eng_done_i(edone4));

  draw_cmd_arbiter #(.NREQ(3), .CORDW(16), .CIDXW(4), .SCALE(1)) u_r3 (
    .clk(clk), .rst(rst), .req_valid_i(valid3), .req_ready_o(ready3), .req_vert_i(vert3),
    .req_cidx_i(cidx3), .cmd_done_o(done3), .grant_id_o(gid3), .busy_o(busy3),
    .eng_start_o(start3), .eng_x0_o(x0_3), .eng_y0_o(y0_3), .eng_x1_o(x1_3),
    .eng_y1_o(y1_3), .eng_x2_o(x2_3), .eng_y2_o(y2_3), .eng_cidx_o(ecidx3),
    .eng_done_i(edone3));

  function automatic logic [95:0] pack6(input int a, b, c, d, e, f);
    return {16'(f), 16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [59:0] pack10(input int a, b, c, d, e, f);
    return {10'(f), 10'(e), 10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({ready, done, gid, busy, start} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {ready, done, gid, busy, start});
    end
    checks++;
    if ({x0, y0, x1, y1, x2, y2, ecidx} !== '0) begin
      errors++;
      $display("FAIL reset_payload: got x0=%0d cidx=%0d expected 0", x0, ecidx);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({ready, start, busy, ready3, start3, busy3} !== 10'd0) begin
        errors++;
        $display("FAIL idle_quiet cycle %0d: got %b expected 0", i,
                 {ready, start, busy, ready3, start3, busy3});
      end
    end
  endtask

  task automatic test_single();
    vert  = {96'd0, pack6(60, 20, 280, 80, 160, 164)};
    cidx  = 8'h03;
    valid = 2'b01;
    #1;
    checks++;
    if (ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", ready); end
    step();  // T+1
    checks++;
    if ({start, busy, gid} !== 3'b110) begin
      errors++; $display("FAIL single_start: got %b expected 110", {start, busy, gid});
    end
    checks++;
    if (x0 !== 16'sd60 || y0 !== 16'sd20 || x1 !== 16'sd280 || y1 !== 16'sd80 ||
        x2 !== 16'sd160 || y2 !== 16'sd164 || ecidx !== 4'd3) begin
      errors++;
      $display("FAIL single_vert: got %0d %0d %0d %0d %0d %0d c%0d expected 60 20 280 80 160 164 c3",
               x0, y0, x1, y1, x2, y2, ecidx);
    end
    valid = 2'b00;
    #1;
    checks++;
    if (ready !== 2'b00) begin errors++; $display("FAIL single_ready_busy: got %b expected 00", ready); end
    step();  // T+2
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b expected 0", start); end
    vert = '1;
    repeat (8) step();  // T+10
    checks++;
    if (x0 !== 16'sd60 || done !== 2'b00 || busy !== 1'b1) begin
      errors++; $display("FAIL single_hold: got x0=%0d done=%b busy=%b expected 60 00 1", x0, done, busy);
    end
    edone = 1'b1;
    step();  // T+11
    edone = 1'b0;
    checks++;
    if (done !== 2'b01 || busy !== 1'b1) begin
      errors++; $display("FAIL single_done: got done=%b busy=%b expected 01 1", done, busy);
    end
    step();  // T+12
    checks++;
    if (done !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL single_after: got done=%b busy=%b expected 00 0", done, busy);
    end
  endtask

  task automatic test_scale2();
    vert  = {96'd0, pack6(160, -5, 7, 0, 0, 0)};
    cidx  = 8'h0a;
    valid = 2'b01;
    step();  // START
    valid = 2'b00;
    checks++;
    if (x0 !== 16'sd160 || s2_x0 !== 16'sd320 || s2_y0 !== -16'sd10 || s2_x1 !== 16'sd14) begin
      errors++;
      $display("FAIL scale2_vert: got x0=%0d s2_x0=%0d s2_y0=%0d s2_x1=%0d expected 160 320 -10 14",
               x0, s2_x0, s2_y0, s2_x1);
    end
    checks++;
    if (s2_start !== 1'b1 || s2_cidx !== 4'ha) begin
      errors++; $display("FAIL scale2_start: got start=%b cidx=%h expected 1 a", s2_start, s2_cidx);
    end
    edone = 1'b1;  // done in the START cycle
    step();
    edone = 1'b0;
    checks++;
    if (done !== 2'b01 || s2_done !== 2'b01) begin
      errors++; $display("FAIL start_done: got %b/%b expected 01/01", done, s2_done);
    end
    step();
    checks++;
    if ({done, busy} !== 3'b000) begin
      errors++; $display("FAIL start_done_after: got %b expected 000", {done, busy});
    end
  endtask

  task automatic test_scale4();
    vert4  = {60'd0, pack10(300, -3, 100, 0, 0, 0)};
    cidx4  = 8'h09;
    valid4 = 2'b01;
    step();
    valid4 = 2'b00;
    checks++;
    if (x0_4 !== 10'sd176 || y0_4 !== -10'sd12 || x1_4 !== 10'sd400 || start4 !== 1'b1) begin
      errors++;
      $display("FAIL scale4_vert: got x0=%0d y0=%0d x1=%0d start=%b expected 176 -12 400 1",
               x0_4, y0_4, x1_4, start4);
    end
    step();  // WAIT
    edone4 = 1'b1;
    step();
    edone4 = 1'b0;
    checks++;
    if (done4 !== 2'b01) begin errors++; $display("FAIL scale4_done: got %b expected 01", done4); end
    step();
  endtask

  task automatic test_spurious_done();
    valid = 2'b00;
    edone = 1'b1;
    step();
    edone = 1'b0;
    checks++;
    if ({done, busy, start} !== 4'd0) begin
      errors++; $display("FAIL spurious_done: got %b expected 0000", {done, busy, start});
    end
    step();
    checks++;
    if ({done, busy, start} !== 4'd0) begin
      errors++; $display("FAIL spurious_done2: got %b expected 0000", {done, busy, start});
    end
  endtask

  task automatic test_reset_mid();
    // ptr is 1 after the earlier requester-0 commands.
    vert  = {pack6(1, 2, 3, 4, 5, 6), pack6(9, 9, 9, 9, 9, 9)};
    cidx  = 8'h57;
    valid = 2'b11;
    #1;
    checks++;
    if (ready !== 2'b10) begin errors++; $display("FAIL rr_ptr_ready: got %b expected 10", ready); end
    step();  // START
    checks++;
    if (gid !== 1'b1 || x0 !== 16'sd1 || ecidx !== 4'd5) begin
      errors++; $display("FAIL rr_ptr_grant: got gid=%0d x0=%0d c=%0d expected 1 1 5", gid, x0, ecidx);
    end
    step();
    step();  // WAIT
    rst = 1'b1;
    step();
    checks++;
    if ({done, busy, start, gid} !== 5'd0 || x0 !== 16'sd0 || ecidx !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: got ctl=%b x0=%0d c=%0d expected 0", {done, busy, start, gid}, x0, ecidx);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ready !== 2'b01) begin errors++; $display("FAIL mid_reset_ready: got %b expected 01", ready); end
    step();  // START for requester 0
    valid = 2'b00;
    checks++;
    if (done !== 2'b00 || gid !== 1'b0 || x0 !== 16'sd9) begin
      errors++; $display("FAIL mid_reset_regrant: got done=%b gid=%0d x0=%0d expected 00 0 9", done, gid, x0);
    end
    step();
    edone = 1'b1;
    step();
    edone = 1'b0;
    checks++;
    if (done !== 2'b01) begin errors++; $display("FAIL mid_reset_done: got %b expected 01", done); end
    step();
  endtask

  task automatic test_round_robin();
    int exp;
    int n;
    vert3  = {pack6(300, 0, 0, 0, 0, 0), pack6(200, 0, 0, 0, 0, 0), pack6(100, 0, 0, 0, 0, 0)};
    cidx3  = {4'd2, 4'd1, 4'd0};
    valid3 = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp = k % 3;
      n = 0;
      step();
      while (!start3 && n < 10) begin
        step();
        n++;
      end
      checks++;
      if (start3 !== 1'b1) begin
        errors++; $display("FAIL rr_start_timeout cmd %0d: got %b expected 1", k, start3);
      end
      checks++;
      if (gid3 !== 2'(exp) || x0_3 !== 16'(100 * (exp + 1)) || ecidx3 !== 4'(exp)) begin
        errors++;
        $display("FAIL rr_order cmd %0d: got gid=%0d x0=%0d c=%0d expected %0d %0d %0d",
                 k, gid3, x0_3, ecidx3, exp, 100 * (exp + 1), exp);
      end
      if (k % 2 == 1) repeat (3) step();
      edone3 = 1'b1;
      step();
      edone3 = 1'b0;
      checks++;
      if (done3 !== (3'b001 << exp)) begin
        errors++; $display("FAIL rr_done cmd %0d: got %b expected %b", k, done3, 3'b001 << exp);
      end
    end
    valid3 = 3'b000;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst    = 1'b1;
    valid  = '0; vert  = '0; cidx  = '0; edone  = 1'b0;
    valid4 = '0; vert4 = '0; cidx4 = '0; edone4 = 1'b0;
    valid3 = '0; vert3 = '0; cidx3 = '0; edone3 = 1'b0;
    test_reset();
    test_single();
    test_scale2();
    test_scale4();
    test_spurious_done();
    test_reset_mid();
    test_round_robin();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
